// File: rtl/riscv_pipe_skid.sv
// rtl/riscv_pipe_skid.sv - elastic two-entry skid pipeline register for the RV32I core
//
// Purpose: carries NCH channels of XLEN bits between pipeline stages with a
// valid/ready handshake. A main entry drives o_data and a skid entry absorbs
// the one extra beat that arrives while downstream stalls. Because the skid
// entry can catch that beat, o_ready can be a flop with no combinational path
// from i_ready.
//
// Ports:
//   i_clk    - clock, all state updates on the rising edge
//   i_rst    - asynchronous active-high reset
//   i_flush  - synchronous flush, discards held and incoming data
//   i_valid  - upstream payload valid
//   o_ready  - stage accepts data this cycle (registered)
//   i_data   - upstream payload, channel k at [k*XLEN +: XLEN]
//   o_valid  - output payload valid
//   i_ready  - downstream accepts o_data this cycle
//   o_data   - output payload, always the main entry
//   o_level  - occupancy 0..2
module riscv_pipe_skid #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     NCH           = 3,
  parameter logic [XLEN-1:0] REGISTER_INIT = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NCH*XLEN-1:0] i_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [NCH*XLEN-1:0] o_data,
  output logic [1:0]          o_level
);

  localparam int unsigned    W         = NCH * XLEN;
  localparam logic [W-1:0]   INIT_WORD = {NCH{REGISTER_INIT}};

  // Encoding doubles as the occupancy count driven on o_level.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   main_q;
  logic [W-1:0]   skid_q;
  logic           in_fire;
  logic           out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  assign o_data   = main_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: begin
        if (in_fire) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (in_fire && !out_fire)      state_nxt = ST_FULL;
        else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (out_fire) state_nxt = ST_BUSY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any handshake; a simultaneous out_fire is treated as
    // already consumed downstream, so nothing is re-presented.
    if (i_flush) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_EMPTY;
      main_q  <= INIT_WORD;
      skid_q  <= INIT_WORD;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_level <= 2'd0;
    end else begin
      state   <= state_nxt;
      // Outputs are registered copies of the next-state decode so that
      // o_ready never sees i_ready combinationally.
      o_ready <= (state_nxt != ST_FULL);
      o_valid <= (state_nxt != ST_EMPTY);
      o_level <= state_nxt;
      if (i_flush) begin
        main_q <= INIT_WORD;
        skid_q <= INIT_WORD;
      end else begin
        unique case (state)
          ST_EMPTY: begin
            if (in_fire) main_q <= i_data;
          end
          ST_BUSY: begin
            if (in_fire && out_fire)       main_q <= i_data;
            else if (in_fire && !out_fire) skid_q <= i_data;
          end
          ST_FULL: begin
            if (out_fire) main_q <= skid_q;
          end
          default: begin
            main_q <= INIT_WORD;
            skid_q <= INIT_WORD;
          end
        endcase
      end
    end
  end

endmodule
